// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: registered load/store stage driving a handshaked 32-bit word bus.
// Optional macro LSU_MISALIGN_TRAP_EN: faulting accesses skip the bus and raise err.
module lsu_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              byte_q, byte_d, half_q, half_d, uns_q, uns_d;
  logic [1:0]        off_q, off_d;

  logic              illegal, is_byte, is_half;
  logic [1:0]        off;
  logic [3:0]        strb;
  logic [DATA_W-1:0] lane_wdata, lane_rdata, ext_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              fault;
`endif

  // Illegal encodings fall back to full-word accesses; low address bits that
  // the effective size does not use are dropped.
  always_comb begin
    illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (req_we && funct3[2]);
    is_byte = !illegal && (funct3[1:0] == 2'b00);
    is_half = !illegal && (funct3[1:0] == 2'b01);
    off     = is_byte ? addr[1:0] : (is_half ? {addr[1], 1'b0} : 2'b00);
    if (is_byte) begin
      strb       = 4'b0001 << off;
      lane_wdata = {4{wdata[7:0]}};
    end else if (is_half) begin
      strb       = 4'b0011 << off;
      lane_wdata = {2{wdata[15:0]}};
    end else begin
      strb       = 4'b1111;
      lane_wdata = wdata;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    fault = illegal || (is_half && addr[0]) ||
            (!illegal && !is_byte && !is_half && (addr[1:0] != 2'b00));
`endif
  end

  always_comb begin
    lane_rdata = mem_rdata >> {off_q, 3'b000};
    if (byte_q)
      ext_rdata = uns_q ? {24'b0, lane_rdata[7:0]} : {{24{lane_rdata[7]}}, lane_rdata[7:0]};
    else if (half_q)
      ext_rdata = uns_q ? {16'b0, lane_rdata[15:0]} : {{16{lane_rdata[15]}}, lane_rdata[15:0]};
    else
      ext_rdata = mem_rdata;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rdata_d     = rdata_q;
    byte_d      = byte_q;
    half_d      = half_q;
    uns_d       = uns_q;
    off_d       = off_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_req_d   = 1'b1;
          mem_we_d    = req_we;
          mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = req_we ? lane_wdata : '0;
          mem_wstrb_d = req_we ? strb : 4'b0000;
          byte_d      = is_byte;
          half_d      = is_half;
          uns_d       = funct3[2];
          off_d       = off;
          state_d     = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (fault) begin
            mem_req_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            rdata_d   = '0;
            state_d   = DONE;
          end
`endif
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = ext_rdata;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      byte_q      <= 1'b0;
      half_q      <= 1'b0;
      uns_q       <= 1'b0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      byte_q      <= byte_d;
      half_q      <= half_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
    end
  end

  assign stall     = !reset && ((state_q == IDLE && req_valid) || state_q == REQ || state_q == WAIT);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store stage directly downstream of the ALU; consumes ALUResult as the effective address and rs2 as store data.
- Runs a registered, handshaked transaction on a 32-bit word-addressed data bus.
- Holds the core via `stall` until the access completes.
- Returns sign- or zero-extended load data for register-file writeback.

Parameters:
- ADDR_W, 32, width of address input and bus address
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  current instruction is a load/store; held high by core while stall=1
- req_we  in  1  1=store, 0=load
- funct3  in  3  RISC-V size/sign field
- addr  in  32  effective address (ALUResult)
- wdata  in  32  store data (rs2)
- stall  out  1  freeze PC/pipeline
- rdata  out  32  extended load data, valid when done=1
- done  out  1  one-cycle completion pulse
- err  out  1  misaligned or illegal-funct3 flag, valid with done
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  word-aligned address, bits[1:0]=0
- mem_wdata  out  32  lane-positioned store data
- mem_wstrb  out  4  byte enables
- mem_gnt  in  1  bus accepted request this cycle
- mem_rvalid  in  1  read data valid; never asserted in the same cycle as its mem_gnt
- mem_rdata  in  32  read word

Behaviour:
- Reset (synchronous):
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, rdata, done, err all 0.
  - stall forced 0 while reset is high.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - req_valid=1: latch addr, wdata, funct3, req_we; next state REQ; with MISALIGN_TRAP_EN and a fault, next state DONE instead.
  - req_valid=0: stay IDLE.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wstrb, mem_wdata stable until mem_gnt.
  - mem_gnt=1 and store: next state DONE.
  - mem_gnt=1 and load: next state WAIT.
  - mem_req drops in the cycle after the grant.
- WAIT: on mem_rvalid, register the extended load value into rdata; next state DONE.
- DONE: done=1 for exactly one cycle; next state IDLE.
- stall: combinational.
  - stall = (state==IDLE & req_valid) | state==REQ | state==WAIT.
  - stall=0 in DONE, so the core advances on that edge.
- Back-to-back accesses: a new req_valid in the cycle after DONE starts normally.
- req_valid deasserting mid-transaction is ignored; the latched transaction completes.
- Reset during REQ/WAIT aborts immediately; the bus must tolerate an abandoned request.
- Minimum latency, zero-wait bus:
  - Store: 2 stall cycles.
  - Load with rvalid one cycle after gnt: 3 stall cycles.
- Stores:
  - SB (000): wstrb = 0001 << addr[1:0]; wdata byte replicated into all 4 lanes.
  - SH (001): wstrb = 0011 << {addr[1],0}; halfword replicated into both halves.
  - SW (010): wstrb = 1111.
- Loads (loads drive mem_wstrb=0):
  - LB 000: selected byte, sign-extended.
  - LH 001: selected half, sign-extended.
  - LW 010: full word.
  - LBU 100: selected byte, zero-extended.
  - LHU 101: selected half, zero-extended.
- Fault conditions: halfword with addr[0]=1; word with addr[1:0]≠0; funct3 ∈ {011,110,111}, or any funct3 with bit2=1 on a store.
- rdata holds its value until the next load's completion.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A fault skips the bus entirely: IDLE→DONE, 1 stall cycle.
  - done=1, err=1, rdata=0; mem_req never asserted.
- Undefined:
  - err tied 0.
  - Offending low address bits are ignored: halfword uses addr[1] only; word ignores addr[1:0].
  - Illegal funct3 is treated as LW/SW.

Test Plan:
- Store word, zero-wait: SW addr=0x100, wdata=0xDEADBEEF, gnt in REQ → mem_addr=0x100, wstrb=1111, stall high 2 cycles, done pulse, mem_req asserted exactly 1 cycle.
- Byte store lanes: SB addr=0x103, wdata=0x000000A5 → wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- Load extension: mem_rdata=0x80F07F81.
  - LB @0x0 → 0xFFFFFF81.
  - LBU @0x3 → 0x00000080.
  - LH @0x2 → 0xFFFF80F0.
  - LHU @0x0 → 0x00007F81.
- Wait states: LW with gnt delayed 3 cycles and rvalid delayed 2 further cycles → mem_req/addr stable throughout REQ, stall=1 until DONE, rdata=mem_rdata; req_valid dropped mid-wait has no effect.
- Misalignment: LW addr=0x102.
  - With macro: no mem_req, err=1, done after 1 stall cycle.
  - Without: mem_addr=0x100, err=0.
- Reset in WAIT: assert reset one cycle → next cycle mem_req=0, stall=0, done=0; a following SW completes normally.
